// File: rtl/rv_pkg.sv
// Shared RV32/RV64 decode constants and the multiply/divide FSM state type.
// Imported by the M-extension unit, the ALU control and the hazard unit.
//   OPCODE_ARITHMETIC : major opcode of register-register ALU ops
//   FUNCT7_MULDIV     : funct7 selecting the M extension
//   F3_*              : funct3 encodings of the eight M ops
//   md_state_t        : muldiv_unit FSM states
package rv_pkg;

    localparam logic [6:0] OPCODE_ARITHMETIC = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV     = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between EX-stage control and muldiv_unit.
//   inst, rs1_data, rs2_data, in_valid, flush : request side (master drives)
//   in_ready                                  : unit can accept (unit drives)
//   result, illegal, out_valid                : response (unit drives)
//   out_ready                                 : consumer takes result (master drives)
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic [31:0]     inst;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output inst, rs1_data, rs2_data, in_valid, flush, out_ready,
        input  in_ready, result, illegal, out_valid
    );

    modport slave (
        input  inst, rs1_data, rs2_data, in_valid, flush, out_ready,
        output in_ready, result, illegal, out_valid
    );
endinterface

// File: rtl/muldiv_decode.sv
// Combinational decode of an instruction word for the M extension.
//   inst      : raw 32-bit instruction
//   is_m      : opcode/funct7 select an M op
//   is_div    : DIV/DIVU/REM/REMU
//   is_rem    : REM/REMU (remainder selected instead of quotient)
//   signed_a  : rs1 is treated as two's complement
//   signed_b  : rs2 is treated as two's complement
//   high_half : MULH/MULHSU/MULHU return the upper product half
module muldiv_decode
    import rv_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_m,
    output logic        is_div,
    output logic        is_rem,
    output logic        signed_a,
    output logic        signed_b,
    output logic        high_half
);
    logic [2:0] funct3;
    logic       unused_fields;

    assign funct3        = inst[14:12];
    // Register specifiers are irrelevant to the operation itself.
    assign unused_fields = ^{inst[24:15], inst[11:7]};

    always_comb begin
        is_m      = (inst[6:0] == OPCODE_ARITHMETIC) && (inst[31:25] == FUNCT7_MULDIV);
        is_div    = funct3[2];
        is_rem    = funct3[2] & funct3[1];
        signed_a  = 1'b0;
        signed_b  = 1'b0;
        high_half = 1'b0;
        case (funct3)
            F3_MULH: begin
                signed_a  = 1'b1;
                signed_b  = 1'b1;
                high_half = 1'b1;
            end
            F3_MULHSU: begin
                signed_a  = 1'b1;
                high_half = 1'b1;
            end
            F3_MULHU: high_half = 1'b1;
            F3_DIV, F3_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply or restoring divide on operand magnitudes, one bit per
// cycle over XLEN cycles, followed by a sign-fix cycle.
//   clk, reset : clock, synchronous active-high reset
//   bus        : muldiv_unit_if slave (request, in_ready, flush, response)
module muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_x(input logic neg, input logic [XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_p(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0]  result_q;
    logic             illegal_q;

    // Working registers: hi = accumulator / partial remainder,
    // lo = multiplier being shifted out / quotient being shifted in.
    logic [XLEN-1:0]  hi, lo, opb;
    logic             op_div, op_rem, op_high, neg_res;

    logic dec_m, dec_div, dec_rem, dec_sa, dec_sb, dec_high;

    muldiv_decode u_decode (
        .inst      (bus.inst),
        .is_m      (dec_m),
        .is_div    (dec_div),
        .is_rem    (dec_rem),
        .signed_a  (dec_sa),
        .signed_b  (dec_sb),
        .high_half (dec_high)
    );

    logic            accept, sign_a, sign_b, div_zero, overflow, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    // Flush blocks a request presented in the same cycle.
    assign accept   = bus.in_valid && (state == IDLE) && !bus.flush;
    assign sign_a   = dec_sa & bus.rs1_data[XLEN-1];
    assign sign_b   = dec_sb & bus.rs2_data[XLEN-1];
    assign abs_a    = neg_x(sign_a, bus.rs1_data);
    assign abs_b    = neg_x(sign_b, bus.rs2_data);
    assign div_zero = dec_div && (bus.rs2_data == '0);
    assign overflow = dec_div && dec_sa && (bus.rs1_data == MOST_NEG) && (bus.rs2_data == '1);
    assign special  = !dec_m || div_zero || overflow;

    always_comb begin
        special_res = '0;
        if (!dec_m)
            special_res = '0;
        else if (div_zero)
            special_res = dec_rem ? bus.rs1_data : '1;
        else if (overflow)
            special_res = dec_rem ? '0 : bus.rs1_data;
    end

    // One iteration step of each algorithm.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_fix, fix_value;

    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {hi, lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    assign prod_fix  = neg_p(neg_res, {hi, lo});
    assign div_fix   = neg_x(neg_res, op_rem ? hi : lo);
    assign fix_value = op_div  ? div_fix :
                       op_high ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (counter == CNT_W'(1))
                    state_nxt = FIX;
            end
            FIX:  state_nxt = bus.flush ? IDLE : DONE;
            DONE: if (bus.flush || bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter   <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (accept && !special)
                counter <= CNT_W'(XLEN);
            else if (state == CALC)
                counter <= counter - 1'b1;

            if (accept && special) begin
                result_q  <= special_res;
                illegal_q <= !dec_m;
            end else if ((state == FIX) && !bus.flush) begin
                result_q  <= fix_value;
                illegal_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hi      <= '0;
            lo      <= abs_a;
            opb     <= abs_b;
            op_div  <= dec_div;
            op_rem  <= dec_rem;
            op_high <= dec_high;
            // Remainder follows the dividend; product and quotient follow sign(A)^sign(B).
            neg_res <= dec_rem ? sign_a : (sign_a ^ sign_b);
        end else if (state == CALC) begin
            if (op_div) begin
                hi <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
                hi <= mul_sum[XLEN:1];
                lo <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   seen;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, OPCODE_ARITHMETIC};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        bus.inst     = ins;
        bus.rs1_data = a;
        bus.rs2_data = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Edge count includes the accept edge.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!bus.out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_ill, input int exp_lat);
        int l;
        issue(ins, a, b);
        wait_done(l);
        check({tag, " latency"}, 64'(l), 64'(exp_lat));
        check({tag, " result"}, 64'(bus.result), 64'(exp_res));
        check({tag, " illegal"}, 64'(bus.illegal), 64'(exp_ill));
        take();
        check({tag, " released"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.inst      = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset illegal", 64'(bus.illegal), 64'd0);

        // Multiplies
        run_op("mul", mk(FUNCT7_MULDIV, F3_MUL), 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
        run_op("mulh", mk(FUNCT7_MULDIV, F3_MULH), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34);
        run_op("mulhu", mk(FUNCT7_MULDIV, F3_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
        run_op("mulhsu", mk(FUNCT7_MULDIV, F3_MULHSU), 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);

        // Divide by zero and signed overflow
        run_op("divu0", mk(FUNCT7_MULDIV, F3_DIVU), 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("rem0", mk(FUNCT7_MULDIV, F3_REM), 32'h1234, 32'd0, 32'h0000_1234, 1'b0, 1);
        run_op("div_ovf", mk(FUNCT7_MULDIV, F3_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op("rem_ovf", mk(FUNCT7_MULDIV, F3_REM), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);

        // Signed division rounding toward zero
        run_op("div_m7_2", mk(FUNCT7_MULDIV, F3_DIV), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("rem_m7_2", mk(FUNCT7_MULDIV, F3_REM), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("remu", mk(FUNCT7_MULDIV, F3_REMU), 32'd100, 32'd7, 32'd2, 1'b0, 34);

        // Backpressure with a waiting request
        issue(mk(FUNCT7_MULDIV, F3_DIVU), 32'd100, 32'd7);
        wait_done(lat);
        check("bp latency", 64'(lat), 64'd34);
        bus.inst     = mk(FUNCT7_MULDIV, F3_MUL);
        bus.rs1_data = 32'd3;
        bus.rs2_data = 32'd5;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", 64'(bus.out_valid), 64'd1);
            check("bp result", 64'(bus.result), 64'd14);
            check("bp in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("bp release out_valid", 64'(bus.out_valid), 64'd0);
        check("bp release in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp late accept", 64'(bus.in_ready), 64'd0);
        wait_done(lat);
        check("bp next latency", 64'(lat), 64'd34);
        check("bp next result", 64'(bus.result), 64'd15);
        take();

        // Illegal instruction (ADD)
        run_op("add illegal", mk(7'b0000000, 3'b000), 32'd5, 32'd6, 32'h0, 1'b1, 1);

        // Flush at cycle 10 of CALC
        issue(mk(FUNCT7_MULDIV, F3_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("flush no output", 64'(seen), 64'd0);

        // Flush in IDLE blocks acceptance
        bus.inst     = mk(FUNCT7_MULDIV, F3_DIVU);
        bus.rs1_data = 32'd9;
        bus.rs2_data = 32'd0;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("idle flush not accepted", 64'(bus.in_ready), 64'd1);
        check("idle flush no output", 64'(bus.out_valid), 64'd0);

        run_op("divu after flush", mk(FUNCT7_MULDIV, F3_DIVU), 32'd100, 32'd7, 32'd14, 1'b0, 34);

        // Reset mid-CALC
        issue(mk(FUNCT7_MULDIV, F3_MUL), 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset in_ready", 64'(bus.in_ready), 64'd1);
        check("midreset out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset result", 64'(bus.result), 64'd0);
        check("midreset illegal", 64'(bus.illegal), 64'd0);

        run_op("mul after reset", mk(FUNCT7_MULDIV, F3_MUL), 32'd6, 32'd7, 32'd42, 1'b0, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
